// File: rtl/ahbl_sram_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM fabric memory stage.
package ahbl_sram_pkg;

    localparam int AHB_DWIDTH = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } fsm_state_e;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahbl_sram_bytewr_ram.sv
// Single-port synchronous word array with byte write enables; a read that
// collides with a write returns the pre-write word.
module ahbl_sram_bytewr_ram
    import ahbl_sram_pkg::*;
#(
    parameter int DEPTH  = 65536,
    parameter int AWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [BYTE_LANES-1:0] byteen,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [AHB_DWIDTH-1:0] wdata,
    output logic [AHB_DWIDTH-1:0] rdata
);

    logic [AHB_DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[addr];
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (byteen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahbl_sram_fabric_mem.sv
// Memory-side stage behind the AHB-Lite SRAM controller: clear sequencer,
// write-port mux, range check and optional output register around the array.
//
//   state | meaning
//   CLEAR | array is being filled with INIT_VALUE, port ignored, init_done = 0
//   READY | port reads/writes serviced, init_done = 1
module ahbl_sram_fabric_mem
    import ahbl_sram_pkg::*;
#(
    parameter int          MEM_DEPTH  = 65536,
    parameter int          MEM_AWIDTH = ceil_log2(MEM_DEPTH),
    parameter int          PIPE       = 1,
    parameter int          INIT_EN    = 1,
    parameter logic [31:0] INIT_VALUE = 32'h0
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [MEM_AWIDTH-1:0] mem_addr,
    input  logic [BYTE_LANES-1:0] mem_byteen,
    input  logic [AHB_DWIDTH-1:0] mem_wdata,
    output logic [AHB_DWIDTH-1:0] mem_rdata,
    input  logic                  init_req,
    output logic                  init_done
);

    fsm_state_e              state_q, state_d;
    logic [MEM_AWIDTH-1:0]   cnt_q;
    logic                    cnt_last;
    logic                    in_range;
    logic                    port_rd;
    logic                    ram_we, ram_re;
    logic [BYTE_LANES-1:0]   ram_be;
    logic [MEM_AWIDTH-1:0]   ram_addr;
    logic [AHB_DWIDTH-1:0]   ram_wdata, ram_rdata;
    logic                    rd_oor_q, rd_seen_q;
    logic [AHB_DWIDTH-1:0]   rd_word;

    assign cnt_last = (cnt_q == MEM_AWIDTH'(MEM_DEPTH - 1));
    assign port_rd  = (state_q == READY) && mem_ren;

    // A power-of-two depth covers the whole address space, so no compare is needed.
    if (MEM_DEPTH == (1 << MEM_AWIDTH)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (int'(mem_addr) < MEM_DEPTH);
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) state_q <= (INIT_EN != 0) ? CLEAR : READY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (cnt_last) state_d = READY;
            READY:   if (init_req) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_be    = '1;
        ram_addr  = cnt_q;
        ram_wdata = INIT_VALUE;
        if (state_q == CLEAR) begin
            ram_we = 1'b1;
        end else begin
            ram_we    = mem_wen && in_range;
            ram_re    = mem_ren && in_range;
            ram_be    = mem_byteen;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            cnt_q     <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= (state_d == READY);
            if (state_q == CLEAR)  cnt_q <= cnt_last ? '0 : cnt_q + MEM_AWIDTH'(1);
            else if (init_req)     cnt_q <= '0;
        end
    end

    ahbl_sram_bytewr_ram #(
        .DEPTH  (MEM_DEPTH),
        .AWIDTH (MEM_AWIDTH)
    ) u_ram (
        .clk    (HCLK),
        .we     (ram_we),
        .re     (ram_re),
        .byteen (ram_be),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    // The array output only changes on a read, so it already holds between reads;
    // rd_seen_q masks the unreset array output until the first read after reset.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            rd_oor_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else if (port_rd) begin
            rd_oor_q  <= !in_range;
            rd_seen_q <= 1'b1;
        end
    end

    assign rd_word = (rd_seen_q && !rd_oor_q) ? ram_rdata : '0;

    if (PIPE == 0) begin : g_pipe0
        assign mem_rdata = rd_word;
    end else begin : g_pipe1
        logic                  rd_vld_q;
        logic [AHB_DWIDTH-1:0] rdata_q;

        always_ff @(posedge HCLK or negedge HRESETN) begin
            if (!HRESETN) begin
                rd_vld_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rd_vld_q <= port_rd;
                if (rd_vld_q) rdata_q <= rd_word;
            end
        end

        assign mem_rdata = rdata_q;
    end

endmodule
